// File: rtl/residual_pkg.sv
// Shared types and element arithmetic for the residual stream adder.
package residual_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int RP_DW = 16;

    // Single-element reference of the datapath: returns {ovf, result}.
    function automatic logic [RP_DW:0] sat_add(
        input logic [RP_DW-1:0] x,
        input logic [RP_DW-1:0] sub,
        input int unsigned      shift,
        input logic             sat
    );
        logic signed [RP_DW:0] s;
        logic                  ov;
        logic [RP_DW-1:0]      r;
        s  = $signed({x[RP_DW-1], x})
           + ($signed({sub[RP_DW-1], sub}) >>> shift);
        ov = s[RP_DW] ^ s[RP_DW-1];
        r  = s[RP_DW-1:0];
        if (ov && sat)
            r = s[RP_DW] ? {1'b1, {(RP_DW-1){1'b0}}}
                         : {1'b0, {(RP_DW-1){1'b1}}};
        return {ov, r};
    endfunction

endpackage

// File: rtl/residual_lane_add.sv
// One lane: shifted add into DW+1 bits, then overflow detect and clamp.
module residual_lane_add #(
    parameter int DATA_WIDTH = 16,
    parameter int SUB_SHIFT  = 0
) (
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-1:0] i_sub,
    output logic [DATA_WIDTH:0]   o_sum,
    input  logic [DATA_WIDTH:0]   i_sum,
    input  logic                  i_sat,
    output logic [DATA_WIDTH-1:0] o_y,
    output logic                  o_ovf
);
    localparam int DW = DATA_WIDTH;

    logic signed [DW:0] w_x;
    logic signed [DW:0] w_sub;

    assign w_x   = $signed({i_x[DW-1], i_x});
    assign w_sub = $signed({i_sub[DW-1], i_sub}) >>> SUB_SHIFT;
    assign o_sum = w_x + w_sub;

    // The clamp half works on the registered sum from the previous stage.
    assign o_ovf = i_sum[DW] ^ i_sum[DW-1];

    always_comb begin
        o_y = i_sum[DW-1:0];
        if (o_ovf && i_sat)
            o_y = i_sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                            : {1'b0, {(DW-1){1'b1}}};
    end

endmodule

// File: rtl/residual_stream_add.sv
// Lane-parallel residual adder y = x + (sub >>> SUB_SHIFT) over one tile,
// two-stage pipeline with valid/ready flow control and sticky overflow.
module residual_stream_add
    import residual_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_LEN    = 8,
    parameter int EMB_DIM    = 8,
    parameter int LANES      = 4,
    parameter int SUB_SHIFT  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        sat_en,
    output logic                        busy,
    output logic                        done,
    output logic                        ovf,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] x_in,
    input  logic [DATA_WIDTH*LANES-1:0] sub_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH*LANES-1:0] y_out,
    output logic                        out_last
);
    localparam int DW    = DATA_WIDTH;
    localparam int SW    = DW + 1;
    localparam int BEATS = SEQ_LEN * EMB_DIM / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    if ((EMB_DIM % LANES) != 0) begin : g_bad_lanes
        $error("EMB_DIM must be a multiple of LANES");
    end
    if (SUB_SHIFT < 0 || SUB_SHIFT >= DATA_WIDTH) begin : g_bad_shift
        $error("SUB_SHIFT out of range");
    end

    state_t              r_state;
    state_t              w_next;
    logic                r_sat;
    logic                r_ovf;
    logic [CW-1:0]       r_in_cnt;
    logic [CW-1:0]       r_out_cnt;
    logic                r_v1;
    logic                r_last1;
    logic [LANES*SW-1:0] r_sum1;
    logic                r_v2;
    logic                r_last2;
    logic [LANES*DW-1:0] r_y2;

    logic [LANES*SW-1:0] w_sum;
    logic [LANES*DW-1:0] w_y;
    logic [LANES-1:0]    w_lane_ovf;
    logic                w_adv1;
    logic                w_adv2;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_start;
    logic                w_beat_ovf;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        residual_lane_add #(
            .DATA_WIDTH(DW),
            .SUB_SHIFT (SUB_SHIFT)
        ) u_lane (
            .i_x  (x_in[k*DW +: DW]),
            .i_sub(sub_in[k*DW +: DW]),
            .o_sum(w_sum[k*SW +: SW]),
            .i_sum(r_sum1[k*SW +: SW]),
            .i_sat(r_sat),
            .o_y  (w_y[k*DW +: DW]),
            .o_ovf(w_lane_ovf[k])
        );
    end

    assign w_adv2     = !r_v2 || out_ready;
    assign w_adv1     = !r_v1 || w_adv2;
    assign in_ready   = (r_state == S_RUN) && (r_in_cnt < BEATS_C) && w_adv1;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_v2 && out_ready;
    assign w_start    = (r_state == S_IDLE) && start;
    assign w_beat_ovf = r_v1 && w_adv2 && (|w_lane_ovf);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_in_cnt == BEATS_C) w_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && r_out_cnt == LAST_C) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sat     <= 1'b0;
            r_ovf     <= 1'b0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_sat     <= sat_en;
                r_ovf     <= 1'b0;
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_in_fire)  r_in_cnt  <= r_in_cnt + 1'b1;
                if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
                if (w_beat_ovf) r_ovf     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_sum1  <= '0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_y2    <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= w_in_fire;
                if (w_in_fire) begin
                    r_sum1  <= w_sum;
                    r_last1 <= (r_in_cnt == LAST_C);
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_y2    <= w_y;
                    r_last2 <= r_last1;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign ovf       = r_ovf;
    assign out_valid = r_v2;
    assign y_out     = r_y2;
    assign out_last  = r_v2 && r_last2;

endmodule

// File: tb/tb_residual_stream_add.sv
// Randomized bench: two instances (SUB_SHIFT 0 and 2) share stimulus and
// are compared against an integer reference model and an expected queue.
module tb_residual_stream_add;
    localparam int BEATS = 16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sat_en;
    logic        in_valid;
    logic [63:0] x_in;
    logic [63:0] sub_in;
    logic        out_ready;

    logic        busy, done, ovf, in_ready, out_valid, out_last;
    logic [63:0] y_out;
    logic        busy_b, done_b, ovf_b, in_ready_b, out_valid_b, out_last_b;
    logic [63:0] y_out_b;

    residual_stream_add #(.SUB_SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sat_en(sat_en),
        .busy(busy), .done(done), .ovf(ovf),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .sub_in(sub_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .out_last(out_last)
    );

    residual_stream_add #(.SUB_SHIFT(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sat_en(sat_en),
        .busy(busy_b), .done(done_b), .ovf(ovf_b),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .x_in(x_in), .sub_in(sub_in),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .y_out(y_out_b), .out_last(out_last_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_pct = 100;
    bit cur_sat;
    bit m_ovf0, m_ovf2;
    int out_idx, done_cnt;
    int first_in, last_in, first_out, last_out;
    bit prev_stall;
    logic [63:0] prev_y;
    logic [63:0] q0[$];
    logic [63:0] q2[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] ref_elem(input logic [15:0] x,
        input logic [15:0] s, input int sh, input bit sat);
        int          xi, si, sum;
        logic [31:0] raw;
        bit          ov;
        logic [15:0] y;
        xi  = int'($signed(x));
        si  = int'($signed(s)) >>> sh;
        sum = xi + si;
        raw = sum;
        ov  = (sum > 32767) || (sum < -32768);
        y   = raw[15:0];
        if (ov && sat) y = (sum > 0) ? 16'h7fff : 16'h8000;
        return {ov, y};
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Scoreboard sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [63:0] e0, e2, g0, g2;
        logic [16:0] r;
        if (!rst_n) begin
            q0.delete();
            q2.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", y_out, prev_y);
            end
            if (q0.size() >= 2 && !out_ready)
                chk("full_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                for (int l = 0; l < 4; l++) begin
                    r = ref_elem(x_in[l*16 +: 16], sub_in[l*16 +: 16], 0, cur_sat);
                    e0[l*16 +: 16] = r[15:0];
                    m_ovf0 |= r[16];
                    r = ref_elem(x_in[l*16 +: 16], sub_in[l*16 +: 16], 2, cur_sat);
                    e2[l*16 +: 16] = r[15:0];
                    m_ovf2 |= r[16];
                end
                q0.push_back(e0);
                q2.push_back(e2);
                if (first_in < 0) first_in = cyc;
                last_in = cyc;
            end
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    g0 = q0.pop_front();
                    g2 = q2.pop_front();
                    chk("y_shift0", y_out, g0);
                    chk("y_shift2", y_out_b, g2);
                    chk("valid_b", out_valid_b, 1);
                    chk("out_last", out_last, (out_idx == BEATS - 1));
                    chk("out_last_b", out_last_b, (out_idx == BEATS - 1));
                end
                out_idx++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_latency", cyc - last_out, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_y = y_out;
        end
    end

    task automatic pattern(input int mode, input int b, input int l,
                           output logic [15:0] x, output logic [15:0] s);
        int e;
        e = b * 4 + l;
        case (mode)
            0: begin x = 16'(e); s = 16'(2 * e); end
            1: begin x = 16'h7000; s = 16'h2000; end
            2: begin x = 16'h8000; s = 16'hffff; end
            3: begin x = 16'h0010; s = (l % 2 == 0) ? 16'hfff0 : 16'h0003; end
            default: begin x = 16'($urandom); s = 16'($urandom); end
        endcase
    endtask

    task automatic send_beat(input int mode, input int b, input int gap_pct,
                             output bit ok);
        logic [15:0] x, s;
        int w;
        if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        for (int l = 0; l < 4; l++) begin
            pattern(mode, b, l, x, s);
            x_in[l*16 +: 16] = x;
            sub_in[l*16 +: 16] = s;
        end
        in_valid = 1;
        ok = 0;
        w = 0;
        while (!ok && w < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        if (!ok) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic begin_tile(input bit sat);
        @(posedge clk);
        #1;
        start = 1;
        sat_en = sat;
        cur_sat = sat;
        m_ovf0 = 0;
        m_ovf2 = 0;
        out_idx = 0;
        done_cnt = 0;
        first_in = -1;
        first_out = -1;
        @(posedge clk);
        #1;
        start = 0;
        sat_en = 1'($urandom);
        chk("busy_after_start", busy, 1);
        chk("ovf_cleared", ovf, 0);
        chk("ovf_b_cleared", ovf_b, 0);
    endtask

    task automatic run_tile(input bit sat, input int mode, input int gap_pct,
                            input bit poke, input bit rate);
        bit ok;
        int n;
        begin_tile(sat);
        for (int b = 0; b < BEATS; b++) begin
            if (poke && b == 5) begin
                start = 1;
                sat_en = !sat;
            end
            send_beat(mode, b, gap_pct, ok);
            if (poke && b == 5) begin
                start = 0;
                chk("poke_busy", busy, 1);
            end
            if (!ok) return;
        end
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("ovf_end", ovf, m_ovf0);
        chk("ovf_b_end", ovf_b, m_ovf2);
        chk("beats_out", out_idx, BEATS);
        chk("queue_empty", q0.size(), 0);
        if (rate) begin
            chk("in_rate", last_in - first_in, BEATS - 1);
            chk("out_rate", last_out - first_out, BEATS - 1);
            chk("latency", first_out - first_in, 2);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("done_count", done_cnt, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_y"}, y_out, 0);
        chk({tag, "_y_b"}, y_out_b, 0);
        chk({tag, "_ovf_b"}, ovf_b, 0);
    endtask

    task automatic abort_tile();
        bit ok;
        rdy_pct = 100;
        begin_tile(0);
        for (int b = 0; b < 8; b++) begin
            send_beat(1, b, 0, ok);
            if (!ok) return;
        end
        rst_n = 0;
        #1;
        check_idle_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        done_cnt = 0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        sat_en = 0;
        in_valid = 0;
        x_in = 0;
        sub_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1;
        @(posedge clk);
        #1;

        rdy_pct = 100;
        run_tile(0, 0, 0, 0, 1);
        run_tile(1, 1, 0, 0, 0);
        run_tile(1, 2, 0, 0, 0);
        run_tile(0, 1, 0, 0, 0);
        run_tile(0, 2, 0, 0, 0);
        run_tile(0, 3, 0, 0, 0);
        run_tile(1, 3, 0, 0, 1);

        rdy_pct = 50;
        for (int t = 0; t < 8; t++)
            run_tile(1'($urandom), 4, 30, 0, 0);

        run_tile(1, 1, 20, 1, 0);
        run_tile(0, 1, 20, 0, 0);
        run_tile(1, 0, 20, 0, 0);

        abort_tile();
        rdy_pct = 50;
        run_tile(1, 4, 30, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
